multicycle_control: RTL and testbench

- Multi-cycle control unit for the 24-bit datapath. Initiator side of the ALU interface: it decodes each instruction opcode and drives aluOp, operand select and the register, memory and PC strobes, one state per cycle.
- It consumes the ALU zero flag to resolve branch-on-equal.
- It sits between the fetch stage (valid/ready handshake) and the datapath/ALU/data memory.

---
 rtl/multicycle_control.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle instruction controller for the 24-bit datapath.
// Takes one opcode at a time from fetch over a valid/ready handshake and steps it
// through DECODE, EXECUTE, MEM and WB. Each state lasts one cycle, except MEM,
// which waits for the memory to answer.
// Optional build macro MEM_TIMEOUT_EN: abort a MEM stall after TIMEOUT_CYCLES
// cycles and pulse fault. Without the macro, MEM waits indefinitely and fault is 0.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       instr_ready,
  output logic [1:0] aluOp,
  output logic       aluSrc,
  output logic       regWrite,
  output logic       memToReg,
  output logic       memRead,
  output logic       memWrite,
  output logic       pcWrite,
  output logic       pcSrc,
  output logic       done,
  output logic       illegal,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_BEQ = 4'b0001;
  localparam logic [3:0] OP_SW  = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLT = 2'b10;

  // The counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("multicycle_control: TIMEOUT_CYCLES must be within 1..255");
  end

  state_t     state_q, state_d;
  logic [3:0] opcode_q;
  logic       done_q, done_d;
  logic       illegal_q, illegal_d;
  logic       mem_timeout;

  function automatic logic is_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_BEQ) || (op == OP_SW) ||
           (op == OP_LW)  || (op == OP_SLT);
  endfunction

  function automatic logic [1:0] alu_op_for(input logic [3:0] op);
    logic [1:0] r;
    r = ALU_ADD;
    if (op == OP_BEQ) r = ALU_SUB;
    else if (op == OP_SLT) r = ALU_SLT;
    return r;
  endfunction

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_LW);
  endfunction

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tcnt_q;
  logic       fault_q;

  // The limit is reached in the MEM cycle where the counter would step to
  // TIMEOUT_CYCLES. A mem_ready arriving in that same cycle still completes.
  assign mem_timeout = (state_q == S_MEM) && !mem_ready && (tcnt_q == TCNT_LAST);

  // Stall counter: held at zero outside MEM, so every MEM visit starts fresh.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q  <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= mem_timeout;
      if (state_q != S_MEM) tcnt_q <= 8'd0;
      else if (!mem_ready)  tcnt_q <= tcnt_q + 8'd1;
    end
  end

  assign fault = fault_q;
`else
  assign mem_timeout = 1'b0;
  assign fault       = 1'b0;
`endif

  // State register. The opcode is latched only at the accept cycle, and the
  // retirement pulses are registered into the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      opcode_q  <= 4'd0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      if (state_q == S_IDLE && instr_valid) opcode_q <= opcode;
    end
  end

  // Next-state logic and the pulse requests raised on the return to IDLE.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_legal(opcode_q)) begin
          state_d = S_EXECUTE;
        end else begin
          state_d   = S_IDLE;
          illegal_d = 1'b1;
        end
      end
      S_EXECUTE: begin
        if (opcode_q == OP_BEQ) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (is_mem_op(opcode_q)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else if (mem_timeout) begin
          state_d = S_IDLE;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode. The one exception is the beq pcWrite, which follows zero.
  always_comb begin
    instr_ready = 1'b0;
    aluOp       = ALU_ADD;
    aluSrc      = 1'b0;
    regWrite    = 1'b0;
    memToReg    = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    pcWrite     = 1'b0;
    pcSrc       = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
      end
      S_DECODE: begin
        pcWrite = 1'b1;
        pcSrc   = 1'b0;
      end
      S_EXECUTE: begin
        aluOp  = alu_op_for(opcode_q);
        aluSrc = is_mem_op(opcode_q);
        if (opcode_q == OP_BEQ) begin
          pcSrc   = 1'b1;
          pcWrite = zero;
        end
      end
      S_MEM: begin
        aluOp    = alu_op_for(opcode_q);
        aluSrc   = 1'b1;
        memRead  = (opcode_q == OP_LW);
        memWrite = (opcode_q == OP_SW);
      end
      S_WB: begin
        regWrite = 1'b1;
        memToReg = (opcode_q == OP_LW);
      end
      default: ;
    endcase
  end

  assign done    = done_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized self-checking bench for multicycle_control.
// For each instruction, the reference model builds the cycle-by-cycle expected
// output trace directly from the instruction rules. Those rules cover the phase
// order, latency and per-phase strobes. The bench then replays the trace against the DUT.
module tb_multicycle_control;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       instr_ready;
  logic [1:0] aluOp;
  logic       aluSrc;
  logic       regWrite;
  logic       memToReg;
  logic       memRead;
  logic       memWrite;
  logic       pcWrite;
  logic       pcSrc;
  logic       done;
  logic       illegal;
  logic       fault;

  multicycle_control #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .zero(zero), .mem_ready(mem_ready), .instr_ready(instr_ready),
    .aluOp(aluOp), .aluSrc(aluSrc), .regWrite(regWrite), .memToReg(memToReg),
    .memRead(memRead), .memWrite(memWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
    .done(done), .illegal(illegal), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef logic [12:0] vec_t;

  localparam logic [2:0] P_NONE = 3'b000;
  localparam logic [2:0] P_DONE = 3'b100;
  localparam logic [2:0] P_ILL  = 3'b010;
  localparam logic [2:0] P_FLT  = 3'b001;

  int checks = 0;
  int errors = 0;

  vec_t       exp_q[$];
  logic       iv_q[$];
  logic [3:0] op_q[$];
  logic       z_q[$];
  logic       mr_q[$];
  logic [2:0] pend;

  logic [12:0] got;
  assign got = {instr_ready, aluOp, aluSrc, regWrite, memToReg, memRead,
                memWrite, pcWrite, pcSrc, done, illegal, fault};

  function automatic vec_t mk(input logic ir, input logic [1:0] aop,
                              input logic asrc, input logic rw, input logic m2r,
                              input logic mrd, input logic mwr, input logic pw,
                              input logic ps, input logic [2:0] pulses);
    return {ir, aop, asrc, rw, m2r, mrd, mwr, pw, ps, pulses};
  endfunction

  function automatic logic rbit();
    return ($urandom & 32'd1) != 32'd0;
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom_range(15, 0));
  endfunction

  function automatic logic [1:0] alu_code(input logic [3:0] op);
    if (op == 4'd1) return 2'b01;
    if (op == 4'd4) return 2'b10;
    return 2'b00;
  endfunction

  task automatic push(input vec_t e, input logic iv, input logic [3:0] op,
                      input logic z, input logic mr);
    exp_q.push_back(e);
    iv_q.push_back(iv);
    op_q.push_back(op);
    z_q.push_back(z);
    mr_q.push_back(mr);
  endtask

  task automatic build_idle(input int n);
    for (int i = 0; i < n; i++) begin
      push(mk(1'b1, 2'b00, 0, 0, 0, 0, 0, 0, 0, pend), 1'b0, rop(), rbit(), rbit());
      pend = P_NONE;
    end
  endtask

  // Expected trace of one instruction, from its accept cycle up to the last
  // non-IDLE cycle. The retirement pulse is carried to the next IDLE cycle.
  task automatic build_instr(input logic [3:0] op, input int stall, input logic z);
    logic is_mem, is_beq, timed_out;
    int   n;
    push(mk(1'b1, 2'b00, 0, 0, 0, 0, 0, 0, 0, pend), 1'b1, op, rbit(), rbit());
    pend = P_NONE;
    push(mk(1'b0, 2'b00, 0, 0, 0, 0, 0, 1, 0, P_NONE), rbit(), rop(), rbit(), rbit());
    if (op > 4'd4) begin
      pend = P_ILL;
      return;
    end
    is_mem = (op == 4'd2) || (op == 4'd3);
    is_beq = (op == 4'd1);
    push(mk(1'b0, alu_code(op), is_mem, 0, 0, 0, 0, is_beq ? z : 1'b0, is_beq, P_NONE),
         rbit(), rop(), z, rbit());
    if (is_beq) begin
      pend = P_DONE;
      return;
    end
    if (is_mem) begin
      timed_out = 1'b0;
      n = stall + 1;
`ifdef MEM_TIMEOUT_EN
      if (stall >= TO) begin
        timed_out = 1'b1;
        n = TO;
      end
`endif
      for (int i = 0; i < n; i++)
        push(mk(1'b0, 2'b00, 1'b1, 0, 0, op == 4'd3, op == 4'd2, 0, 0, P_NONE),
             rbit(), rop(), rbit(), i == stall);
      if (timed_out) begin
        pend = P_FLT;
        return;
      end
      if (op == 4'd2) begin
        pend = P_DONE;
        return;
      end
    end
    push(mk(1'b0, 2'b00, 0, 1'b1, op == 4'd3, 0, 0, 0, 0, P_NONE),
         rbit(), rop(), rbit(), rbit());
    pend = P_DONE;
  endtask

  task automatic run_queue(input string name, input int limit);
    int n;
    n = exp_q.size();
    if (limit >= 0 && limit < n) n = limit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      instr_valid = iv_q[i];
      opcode      = op_q[i];
      zero        = z_q[i];
      mem_ready   = mr_q[i];
      #1;
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d got %b expected %b", name, i, got, exp_q[i]);
      end
    end
    exp_q.delete();
    iv_q.delete();
    op_q.delete();
    z_q.delete();
    mr_q.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reset       = 1'b1;
      instr_valid = rbit();
      opcode      = rop();
      mem_ready   = rbit();
      #1;
      checks++;
      if (got !== mk(1'b1, 2'b00, 0, 0, 0, 0, 0, 0, 0, P_NONE)) begin
        errors++;
        $display("FAIL reset_state got %b expected %b", got,
                 mk(1'b1, 2'b00, 0, 0, 0, 0, 0, 0, 0, P_NONE));
      end
    end
    @(negedge clk);
    reset       = 1'b0;
    instr_valid = 1'b0;
    #1;
    checks++;
    if (got !== mk(1'b1, 2'b00, 0, 0, 0, 0, 0, 0, 0, P_NONE)) begin
      errors++;
      $display("FAIL reset_release got %b expected %b", got,
               mk(1'b1, 2'b00, 0, 0, 0, 0, 0, 0, 0, P_NONE));
    end
    pend = P_NONE;
  endtask

  task automatic test_add();
    build_instr(4'd0, 0, 1'b0);
    run_queue("add", -1);
  endtask

  task automatic test_beq();
    build_instr(4'd1, 0, 1'b1);
    build_instr(4'd1, 0, 1'b0);
    run_queue("beq", -1);
  endtask

  task automatic test_mem_stall();
    build_instr(4'd3, 3, rbit());
    build_instr(4'd2, 3, rbit());
    build_idle(1);
    run_queue("mem_stall", -1);
  endtask

  task automatic test_illegal();
    build_instr(4'd15, 0, 1'b0);
    build_instr(4'd0, 0, 1'b0);
    build_instr(4'd9, 0, 1'b0);
    build_idle(1);
    run_queue("illegal", -1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    for (int k = 0; k < 40; k++) begin
      build_idle($urandom_range(2, 0));
      if ($urandom_range(7, 0) == 0) op = 4'($urandom_range(15, 5));
      else                           op = 4'($urandom_range(4, 0));
      build_instr(op, $urandom_range(6, 0), rbit());
    end
    build_idle(1);
    run_queue("random", -1);
  endtask

  task automatic test_timeout();
    build_instr(4'd2, 8, 1'b0);
    build_idle(2);
    run_queue("mem_timeout", -1);
  endtask

  task automatic test_reset_mid();
    vec_t e;
    build_instr(4'd3, 10, 1'b0);
    run_queue("reset_mid_pre", 5);
    pend = P_NONE;
    @(negedge clk);
    reset       = 1'b1;
    instr_valid = 1'b1;
    opcode      = rop();
    mem_ready   = 1'b0;
    #1;
    e = mk(1'b0, 2'b00, 1'b1, 0, 0, 1'b1, 0, 0, 0, P_NONE);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL reset_mid_hold got %b expected %b", got, e);
    end
    e = mk(1'b1, 2'b00, 0, 0, 0, 0, 0, 0, 0, P_NONE);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset       = 1'b0;
      instr_valid = 1'b0;
      mem_ready   = rbit();
      #1;
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid_idle cycle %0d got %b expected %b", i, got, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    opcode      = 4'd0;
    zero        = 1'b0;
    mem_ready   = 1'b0;
    pend        = P_NONE;
    test_reset();
    test_add();
    test_beq();
    test_mem_stall();
    test_illegal();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_add();
    build_idle(1);
    run_queue("final", -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
